mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one unified memory port between the core's instruction-fetch port (imem_*) and data port (dmem_*).
- Sits between minuteCore and a single memory model; replaces the separate imem/dmem instances in the top-level bench.
- Serialises requests, one outstanding transaction at a time.
- Includes a transaction watchdog that aborts a memory access that never completes.

Parameters:
- ADDR_W, 32, address width (matches `ADDR_SIZE+1).
- DATA_W, 32, data width (matches `INSTR_SIZE+1).
- TIMEOUT, 16, max busy cycles before abort; 0 disables the watchdog.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- imem_rd_addr  in  ADDR_W  fetch address.
- imem_rd_enable  in  1  fetch request; held until imem_rd_ready.
- imem_rd_data  out  DATA_W  fetch data; valid when imem_rd_ready=1.
- imem_rd_ready  out  1  fetch complete (1-cycle pulse).
- dmem_addr  in  ADDR_W  data address.
- dmem_r_enable  in  1  load request; held until dmem_ready.
- dmem_w_enable  in  1  store request; held until dmem_ready.
- dmem_w_size  in  2  store size (0=byte, 1=half, 2=word).
- dmem_w_data  in  DATA_W  store data.
- dmem_r_data  out  DATA_W  load data; valid when dmem_ready=1.
- dmem_ready  out  1  data access complete (1-cycle pulse).
- mem_addr  out  ADDR_W  to memory.
- mem_r_enable  out  1  to memory.
- mem_w_enable  out  1  to memory.
- mem_w_size  out  2  to memory.
- mem_w_data  out  DATA_W  to memory.
- mem_r_data  in  DATA_W  from memory.
- mem_ready  in  1  from memory; completes current access.
- arb_err  out  1  1-cycle pulse on watchdog abort.

Behaviour:
- States: IDLE, IBUSY, DBUSY. Reset (async, any time) forces IDLE, clears the watchdog counter and the last-grant flag, and drives all outputs to 0 immediately.
- IDLE:
  - Memory enables are 0; nothing is forwarded.
  - If any dmem request (r or w) is present -> DBUSY.
  - Else if imem_rd_enable -> IBUSY.
  - dmem_r_enable and dmem_w_enable together is illegal; w takes precedence and r is ignored.
- IBUSY/DBUSY:
  - mem_addr, mem_*_enable, mem_w_size and mem_w_data are combinationally muxed from the granted requester. mem_w_enable=0 in IBUSY.
  - The granted requester's ready = mem_ready, and its read data = mem_r_data, both combinational. The non-granted requester sees ready=0 and data=0.
  - On mem_ready=1 -> IDLE.
- Latency:
  - Request sampled in IDLE at cycle N; memory sees enable from cycle N+1.
  - Ready reaches the requester in the same cycle memory asserts it.
  - One mandatory IDLE bubble separates back-to-back transactions.
- Requester abandons mid-transaction (its enable drops while granted):
  - Memory enables follow to 0 combinationally.
  - State -> IDLE at the next edge; no ready is returned.
- Simultaneous imem and dmem requests in IDLE: dmem wins (fixed priority, unless ARB_RR_EN). The imem request stays pending and is served after the dmem ready.
- Watchdog (TIMEOUT>0):
  - Counter clears on entry to a BUSY state and increments each BUSY cycle without mem_ready.
  - When the count reaches TIMEOUT:
    - the granted requester receives ready=1 with data=0;
    - arb_err pulses;
    - memory enables are forced 0 for that cycle;
    - state -> IDLE.
  - mem_ready arriving in the same cycle as the timeout takes precedence: normal completion, no arb_err.
- Width rules: addresses and data pass through unmodified; no alignment checking.

Optional Feature:
- Macro: ARB_RR_EN.
- Defined:
  - A last-grant flag is updated on every grant, including aborted ones.
  - On contention in IDLE, the requester not granted last time wins.
  - The flag resets to "imem granted last", so the first contention goes to dmem.
- Undefined: fixed dmem priority; the flag logic is absent.

Test Plan:
- Reset: reset=1 with imem_rd_enable=1 and dmem_w_enable=1 -> all outputs 0; after release, the first grant is DBUSY.
- Single fetch: imem_rd_enable=1, addr=0x10, memory returns 0x00500093 with mem_ready in its second cycle -> mem_addr=0x10 from cycle N+1, imem_rd_ready pulses with imem_rd_data=0x00500093, and the next cycle is IDLE.
- Contention: imem (addr 0x20) and dmem store (addr 0x100, w_data=0xDEADBEEF, size=2) asserted together:
  - without ARB_RR_EN: store first, then fetch, with one IDLE bubble between;
  - with ARB_RR_EN: alternates dmem, imem, dmem over repeated contention.
- Watchdog: TIMEOUT=4, dmem_r_enable=1, mem_ready held 0 -> on the 4th BUSY cycle dmem_ready=1, dmem_r_data=0, arb_err=1 for one cycle; then IDLE.
- Abandon: imem_rd_enable dropped in the 2nd IBUSY cycle -> mem_r_enable=0 in the same cycle, no imem_rd_ready, IDLE next cycle.
- Mid-operation reset: reset asserted between clock edges during DBUSY -> mem_w_enable falls immediately; after release, a pending imem request is granted normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbitrates one unified memory port between instruction fetch and data access,
// one transaction at a time, with a watchdog. Define ARB_RR_EN for round-robin contention.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] imem_rd_addr,
  input  logic              imem_rd_enable,
  output logic [DATA_W-1:0] imem_rd_data,
  output logic              imem_rd_ready,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic              dmem_r_enable,
  input  logic              dmem_w_enable,
  input  logic [1:0]        dmem_w_size,
  input  logic [DATA_W-1:0] dmem_w_data,
  output logic [DATA_W-1:0] dmem_r_data,
  output logic              dmem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_r_enable,
  output logic              mem_w_enable,
  output logic [1:0]        mem_w_size,
  output logic [DATA_W-1:0] mem_w_data,
  input  logic [DATA_W-1:0] mem_r_data,
  input  logic              mem_ready,
  output logic              arb_err
);

  typedef enum logic [1:0] {
    IDLE,
    IBUSY,
    DBUSY
  } state_t;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dmemReq;
  logic             grantDmem;
  logic             timeoutHit;

  assign dmemReq    = dmem_r_enable | dmem_w_enable;
  // The abort fires in the TIMEOUT-th busy cycle, i.e. when the count of prior idle-memory cycles is TIMEOUT-1.
  assign timeoutHit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

`ifdef ARB_RR_EN
  logic lastDmem_q, lastDmem_d;

  // Under contention, whichever side was not granted last time wins.
  assign grantDmem = dmemReq && (!imem_rd_enable || !lastDmem_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lastDmem_q <= 1'b0;
    else       lastDmem_q <= lastDmem_d;
  end
`else
  assign grantDmem = dmemReq;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    imem_rd_data  = '0;
    imem_rd_ready = 1'b0;
    dmem_r_data   = '0;
    dmem_ready    = 1'b0;
    mem_addr      = '0;
    mem_r_enable  = 1'b0;
    mem_w_enable  = 1'b0;
    mem_w_size    = 2'd0;
    mem_w_data    = '0;
    arb_err       = 1'b0;
`ifdef ARB_RR_EN
    lastDmem_d    = lastDmem_q;
`endif

    case (state_q)
      IDLE: begin
        if (grantDmem) begin
          state_d = DBUSY;
          cnt_d   = '0;
`ifdef ARB_RR_EN
          lastDmem_d = 1'b1;
`endif
        end else if (imem_rd_enable) begin
          state_d = IBUSY;
          cnt_d   = '0;
`ifdef ARB_RR_EN
          lastDmem_d = 1'b0;
`endif
        end
      end

      IBUSY: begin
        mem_addr = imem_rd_addr;
        if (!imem_rd_enable) begin
          state_d = IDLE;
        end else if (mem_ready) begin
          mem_r_enable  = 1'b1;
          imem_rd_ready = 1'b1;
          imem_rd_data  = mem_r_data;
          state_d       = IDLE;
        end else if (timeoutHit) begin
          imem_rd_ready = 1'b1;
          arb_err       = 1'b1;
          state_d       = IDLE;
        end else begin
          mem_r_enable = 1'b1;
          imem_rd_data = mem_r_data;
          cnt_d        = cnt_q + CNT_W'(1);
        end
      end

      DBUSY: begin
        mem_addr   = dmem_addr;
        mem_w_size = dmem_w_size;
        mem_w_data = dmem_w_data;
        if (!dmemReq) begin
          state_d = IDLE;
        end else if (mem_ready) begin
          mem_w_enable = dmem_w_enable;
          mem_r_enable = dmem_r_enable & ~dmem_w_enable;
          dmem_ready   = 1'b1;
          dmem_r_data  = mem_r_data;
          state_d      = IDLE;
        end else if (timeoutHit) begin
          dmem_ready = 1'b1;
          arb_err    = 1'b1;
          state_d    = IDLE;
        end else begin
          mem_w_enable = dmem_w_enable;
          mem_r_enable = dmem_r_enable & ~dmem_w_enable;
          dmem_r_data  = mem_r_data;
          cnt_d        = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven checks of mem_arbiter (TIMEOUT=4), plus hand-written reset and contention sequences.
module tb_mem_arbiter;

  typedef struct packed {
    logic        iEn;
    logic [31:0] iAddr;
    logic        dR;
    logic        dW;
    logic [1:0]  dSize;
    logic [31:0] dAddr;
    logic [31:0] dWData;
    logic        mRdy;
    logic [31:0] mRData;
  } in_t;

  typedef struct packed {
    logic [31:0] mAddr;
    logic        mR;
    logic        mW;
    logic [1:0]  mSize;
    logic [31:0] mWData;
    logic        iRdy;
    logic [31:0] iData;
    logic        dRdy;
    logic [31:0] dData;
    logic        err;
  } outs_t;

  typedef struct packed {
    in_t   stim;
    outs_t exp;
  } vec_t;

  logic        clk;
  logic        reset;
  logic [31:0] imemRdAddr;
  logic        imemRdEnable;
  logic [31:0] imemRdData;
  logic        imemRdReady;
  logic [31:0] dmemAddr;
  logic        dmemREnable;
  logic        dmemWEnable;
  logic [1:0]  dmemWSize;
  logic [31:0] dmemWData;
  logic [31:0] dmemRData;
  logic        dmemReady;
  logic [31:0] memAddr;
  logic        memREnable;
  logic        memWEnable;
  logic [1:0]  memWSize;
  logic [31:0] memWData;
  logic [31:0] memRData;
  logic        memReady;
  logic        arbErr;

  int checks = 0;
  int passes = 0;
  vec_t vecs[$];

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .imem_rd_addr(imemRdAddr), .imem_rd_enable(imemRdEnable),
    .imem_rd_data(imemRdData), .imem_rd_ready(imemRdReady),
    .dmem_addr(dmemAddr), .dmem_r_enable(dmemREnable), .dmem_w_enable(dmemWEnable),
    .dmem_w_size(dmemWSize), .dmem_w_data(dmemWData),
    .dmem_r_data(dmemRData), .dmem_ready(dmemReady),
    .mem_addr(memAddr), .mem_r_enable(memREnable), .mem_w_enable(memWEnable),
    .mem_w_size(memWSize), .mem_w_data(memWData),
    .mem_r_data(memRData), .mem_ready(memReady), .arb_err(arbErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic in_t mkIn(logic iEn, logic [31:0] iAddr, logic dR, logic dW,
                               logic [1:0] dSize, logic [31:0] dAddr, logic [31:0] dWData,
                               logic mRdy, logic [31:0] mRData);
    in_t s;
    s = '{iEn, iAddr, dR, dW, dSize, dAddr, dWData, mRdy, mRData};
    return s;
  endfunction

  function automatic outs_t mkOut(logic [31:0] mAddr, logic mR, logic mW, logic [1:0] mSize,
                                  logic [31:0] mWData, logic iRdy, logic [31:0] iData,
                                  logic dRdy, logic [31:0] dData, logic err);
    outs_t o;
    o = '{mAddr, mR, mW, mSize, mWData, iRdy, iData, dRdy, dData, err};
    return o;
  endfunction

  task automatic addVec(input in_t s, input outs_t e);
    vec_t v;
    v.stim = s;
    v.exp  = e;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input in_t s);
    imemRdEnable = s.iEn;
    imemRdAddr   = s.iAddr;
    dmemREnable  = s.dR;
    dmemWEnable  = s.dW;
    dmemWSize    = s.dSize;
    dmemAddr     = s.dAddr;
    dmemWData    = s.dWData;
    memReady     = s.mRdy;
    memRData     = s.mRData;
  endtask

  task automatic checkOutput(input string nm, input outs_t e);
    outs_t act;
    act = '{memAddr, memREnable, memWEnable, memWSize, memWData,
            imemRdReady, imemRdData, dmemReady, dmemRData, arbErr};
    checks++;
    if (act !== e)
      $display("[TB] FAIL %s: got %h expected %h", nm, act, e);
    else
      passes++;
  endtask

  task automatic stepCycle(input string nm, input in_t s, input outs_t e);
    @(negedge clk);
    applyStimulus(s);
    #1;
    checkOutput(nm, e);
  endtask

  initial begin
    in_t   zin, both, bothRdy;
    outs_t zout, expD, expI, exp2;
    zin  = '0;
    zout = '0;
    reset = 1'b1;
    applyStimulus(zin);

    // Main vector table: one record per clock cycle, starting from IDLE.
    addVec(mkIn(1, 32'h10, 0, 0, 0, 0, 0, 0, 0), zout);
    addVec(mkIn(1, 32'h10, 0, 0, 0, 0, 0, 0, 0), mkOut(32'h10, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    addVec(mkIn(1, 32'h10, 0, 0, 0, 0, 0, 1, 32'h00500093),
           mkOut(32'h10, 1, 0, 0, 0, 1, 32'h00500093, 0, 0, 0));
    addVec(mkIn(0, 0, 0, 0, 0, 0, 0, 0, 32'h1234), zout);
    addVec(mkIn(0, 0, 1, 0, 0, 32'h200, 0, 0, 0), zout);
    addVec(mkIn(0, 0, 1, 0, 0, 32'h200, 0, 0, 0), mkOut(32'h200, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    addVec(mkIn(0, 0, 1, 0, 0, 32'h200, 0, 1, 32'hCAFEF00D),
           mkOut(32'h200, 1, 0, 0, 0, 0, 0, 1, 32'hCAFEF00D, 0));
    addVec(zin, zout);
    addVec(mkIn(0, 0, 0, 1, 1, 32'h104, 32'hBEEF, 0, 0), zout);
    addVec(mkIn(0, 0, 0, 1, 1, 32'h104, 32'hBEEF, 1, 0),
           mkOut(32'h104, 0, 1, 1, 32'hBEEF, 0, 0, 1, 0, 0));
    addVec(zin, zout);
    addVec(mkIn(0, 0, 1, 1, 2, 32'h300, 32'h11223344, 0, 0), zout);
    addVec(mkIn(0, 0, 1, 1, 2, 32'h300, 32'h11223344, 1, 0),
           mkOut(32'h300, 0, 1, 2, 32'h11223344, 0, 0, 1, 0, 0));
    addVec(zin, zout);
    addVec(mkIn(0, 0, 1, 0, 0, 32'h400, 0, 0, 32'hBAD0BAD0), zout);
    for (int k = 0; k < 3; k++)
      addVec(mkIn(0, 0, 1, 0, 0, 32'h400, 0, 0, 32'hBAD0BAD0),
             mkOut(32'h400, 1, 0, 0, 0, 0, 0, 0, 32'hBAD0BAD0, 0));
    addVec(mkIn(0, 0, 1, 0, 0, 32'h400, 0, 0, 32'hBAD0BAD0),
           mkOut(32'h400, 0, 0, 0, 0, 0, 0, 1, 0, 1));
    addVec(zin, zout);
    addVec(mkIn(0, 0, 1, 0, 0, 32'h500, 0, 0, 0), zout);
    for (int k = 0; k < 3; k++)
      addVec(mkIn(0, 0, 1, 0, 0, 32'h500, 0, 0, 0), mkOut(32'h500, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    addVec(mkIn(0, 0, 1, 0, 0, 32'h500, 0, 1, 32'h55),
           mkOut(32'h500, 1, 0, 0, 0, 0, 0, 1, 32'h55, 0));
    addVec(zin, zout);
    addVec(mkIn(1, 32'h30, 0, 0, 0, 0, 0, 0, 0), zout);
    addVec(mkIn(1, 32'h30, 0, 0, 0, 0, 0, 0, 0), mkOut(32'h30, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    addVec(mkIn(0, 32'h30, 0, 0, 0, 0, 0, 0, 0), mkOut(32'h30, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    addVec(mkIn(1, 32'h30, 0, 0, 0, 0, 0, 0, 0), zout);
    addVec(mkIn(1, 32'h30, 0, 0, 0, 0, 0, 1, 32'h77),
           mkOut(32'h30, 1, 0, 0, 0, 1, 32'h77, 0, 0, 0));
    addVec(zin, zout);

    // Reset held with both requests pending, then the first contention round.
    both = mkIn(1, 32'h20, 0, 1, 2, 32'h100, 32'hDEADBEEF, 0, 0);
    stepCycle("rst_outputs", both, zout);
    #2 reset = 1'b0;
    stepCycle("c1_store_first", mkIn(1, 32'h20, 0, 1, 2, 32'h100, 32'hDEADBEEF, 1, 0),
              mkOut(32'h100, 0, 1, 2, 32'hDEADBEEF, 0, 0, 1, 0, 0));
    stepCycle("c1_bubble", mkIn(1, 32'h20, 0, 0, 0, 0, 0, 0, 0), zout);
    stepCycle("c1_fetch", mkIn(1, 32'h20, 0, 0, 0, 0, 0, 1, 32'h00500093),
              mkOut(32'h20, 1, 0, 0, 0, 1, 32'h00500093, 0, 0, 0));
    stepCycle("c1_done", zin, zout);

    // Both requesters held through three back-to-back grants.
    bothRdy = mkIn(1, 32'h20, 0, 1, 2, 32'h100, 32'hDEADBEEF, 1, 32'hABCD);
    expD = mkOut(32'h100, 0, 1, 2, 32'hDEADBEEF, 0, 0, 1, 32'hABCD, 0);
    expI = mkOut(32'h20, 1, 0, 0, 0, 1, 32'hABCD, 0, 0, 0);
`ifdef ARB_RR_EN
    exp2 = expI;
`else
    exp2 = expD;
`endif
    stepCycle("c2_idle0", both, zout);
    stepCycle("c2_grant1", bothRdy, expD);
    stepCycle("c2_idle1", both, zout);
    stepCycle("c2_grant2", bothRdy, exp2);
    stepCycle("c2_idle2", both, zout);
    stepCycle("c2_grant3", bothRdy, expD);
    stepCycle("c2_done", zin, zout);

    foreach (vecs[k]) stepCycle($sformatf("vec%0d", k), vecs[k].stim, vecs[k].exp);

    // Reset between edges while a store is in flight.
    stepCycle("mr_idle", mkIn(0, 0, 0, 1, 0, 32'h600, 32'hAB, 0, 0), zout);
    stepCycle("mr_busy", mkIn(1, 32'h40, 0, 1, 0, 32'h600, 32'hAB, 0, 0),
              mkOut(32'h600, 0, 1, 0, 32'hAB, 0, 0, 0, 0, 0));
    #2 reset = 1'b1;
    #1 checkOutput("mr_reset_now", zout);
    stepCycle("mr_held", mkIn(1, 32'h40, 0, 0, 0, 0, 0, 0, 0), zout);
    #2 reset = 1'b0;
    stepCycle("mr_grant", mkIn(1, 32'h40, 0, 0, 0, 0, 0, 1, 32'h99),
              mkOut(32'h40, 1, 0, 0, 0, 1, 32'h99, 0, 0, 0));
    stepCycle("mr_done", zin, zout);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
